// File: rtl/gpsreceiver2_capture.sv
// gpsreceiver2_capture: packs 2-bit sign/magnitude GPS samples four per byte
// and streams them into the byte port of the sample buffer, controlled by a
// small CSR bank. Single-shot or continuous (ring) capture, irq on completion
// or wrap.
// Optional feature macro: GPSRECEIVER2_CAPTURE_TRIGGER_EN -- when defined,
// start arms the engine and capture begins on the next pps rising edge.
module gpsreceiver2_capture #(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        smp_stb,
  input  logic        smp_sign,
  input  logic        smp_mag,
  input  logic        pps,
  output logic [7:0]  rxb_dat,
  output logic [10:0] rxb_adr,
  output logic        rxb_we,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d, len_run_q, len_run_d;
  logic        cont_q, cont_d, cont_run_q, cont_run_d;
  logic [10:0] adr_q, adr_d;
  logic [11:0] count_q, count_d;
  logic [15:0] wraps_q, wraps_d;
  logic        done_q, done_d;
  logic        fin_q, fin_d;       // last single-shot byte written, retire next cycle
  logic [1:0]  slot_q, slot_d;
  logic [5:0]  pack_q, pack_d;     // slots 0..2 of the byte being assembled
  logic [7:0]  rxb_dat_q, rxb_dat_d;
  logic [10:0] rxb_adr_q, rxb_adr_d;
  logic        rxb_we_q, rxb_we_d;
  logic        irq_q, irq_d;
  logic [31:0] csr_do_q, csr_do_d;

  logic        sel, wr, wr_ctrl, start, abort, busy, pps_rise;
  logic [10:0] last_adr;

  // Address bits below the register field and upper write-data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{pps, csr_a[9:3], csr_di[31:11]};

  assign sel      = (csr_a[13:10] == csr_addr);
  assign wr       = sel && csr_we;
  assign wr_ctrl  = wr && (csr_a[2:0] == 3'd0);
  assign start    = wr_ctrl && csr_di[0];
  assign abort    = wr_ctrl && csr_di[1];
  assign busy     = (state_q != IDLE);
  // LENGTH=0 wraps to 2047 here, i.e. a 2048-byte run.
  assign last_adr = len_run_q - 11'd1;

`ifdef GPSRECEIVER2_CAPTURE_TRIGGER_EN
  logic pps_q;
  // Registered pps for rising-edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) pps_q <= 1'b0;
    else         pps_q <= pps;
  end
  assign pps_rise = pps && !pps_q;
`else
  assign pps_rise = 1'b0;
`endif

  // Next-state: CSR writes, capture FSM, packer and buffer write port.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cont_d     = cont_q;
    len_run_d  = len_run_q;
    cont_run_d = cont_run_q;
    adr_d      = adr_q;
    count_d    = count_q;
    wraps_d    = wraps_q;
    done_d     = done_q;
    fin_d      = fin_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    rxb_dat_d  = rxb_dat_q;
    rxb_adr_d  = rxb_adr_q;
    rxb_we_d   = 1'b0;
    irq_d      = 1'b0;

    if (wr && csr_a[2:0] == 3'd1) len_d = csr_di[10:0];
    if (wr_ctrl)                  cont_d = csr_di[2];

    if (abort) begin
      state_d = IDLE;
      fin_d   = 1'b0;
      slot_d  = 2'd0;
      pack_d  = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef GPSRECEIVER2_CAPTURE_TRIGGER_EN
            state_d = ARMED;
`else
            state_d = CAPTURE;
`endif
            len_run_d  = len_q;
            cont_run_d = csr_di[2];
            adr_d      = 11'd0;
            count_d    = 12'd0;
            wraps_d    = 16'd0;
            done_d     = 1'b0;
            fin_d      = 1'b0;
            slot_d     = 2'd0;
            pack_d     = 6'd0;
          end
        end
        ARMED: begin
          if (pps_rise) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (fin_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fin_d   = 1'b0;
          end else if (smp_stb) begin
            if (slot_q == 2'd3) begin
              rxb_we_d  = 1'b1;
              rxb_dat_d = {smp_sign, smp_mag, pack_q};
              rxb_adr_d = adr_q;
              slot_d    = 2'd0;
              pack_d    = 6'd0;
              adr_d     = adr_q + 11'd1;
              count_d   = count_q + 12'd1;
              if (adr_q == last_adr) begin
                irq_d = 1'b1;
                if (cont_run_q) begin
                  adr_d   = 11'd0;
                  count_d = 12'd0;
                  wraps_d = (wraps_q == 16'hFFFF) ? wraps_q : wraps_q + 16'd1;
                end else begin
                  fin_d = 1'b1;
                end
              end
            end else begin
              // Shift in from the top so slot 0 ends up in bits [1:0].
              slot_d = slot_q + 2'd1;
              pack_d = {smp_sign, smp_mag, pack_q[5:2]};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // CSR read mux, zero when the bank is not addressed.
  always_comb begin
    csr_do_d = 32'd0;
    if (sel) begin
      case (csr_a[2:0])
        3'd0:    csr_do_d = {26'd0, state_q, 1'b0, cont_q, done_q, busy};
        3'd1:    csr_do_d = {21'd0, len_q};
        3'd2:    csr_do_d = {20'd0, count_q};
        3'd3:    csr_do_d = {16'd0, wraps_q};
        default: csr_do_d = 32'd0;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      len_q      <= 11'd0;
      cont_q     <= 1'b0;
      len_run_q  <= 11'd0;
      cont_run_q <= 1'b0;
      adr_q      <= 11'd0;
      count_q    <= 12'd0;
      wraps_q    <= 16'd0;
      done_q     <= 1'b0;
      fin_q      <= 1'b0;
      slot_q     <= 2'd0;
      pack_q     <= 6'd0;
      rxb_dat_q  <= 8'd0;
      rxb_adr_q  <= 11'd0;
      rxb_we_q   <= 1'b0;
      irq_q      <= 1'b0;
      csr_do_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cont_q     <= cont_d;
      len_run_q  <= len_run_d;
      cont_run_q <= cont_run_d;
      adr_q      <= adr_d;
      count_q    <= count_d;
      wraps_q    <= wraps_d;
      done_q     <= done_d;
      fin_q      <= fin_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
      rxb_dat_q  <= rxb_dat_d;
      rxb_adr_q  <= rxb_adr_d;
      rxb_we_q   <= rxb_we_d;
      irq_q      <= irq_d;
      csr_do_q   <= csr_do_d;
    end
  end

  assign csr_do  = csr_do_q;
  assign rxb_dat = rxb_dat_q;
  assign rxb_adr = rxb_adr_q;
  assign rxb_we  = rxb_we_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Randomized bench for gpsreceiver2_capture: expected buffer writes, irq
// pulses and CSR values come from a sample-list reference model.
module tb_gpsreceiver2_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        smp_stb, smp_sign, smp_mag, pps;
  logic [7:0]  rxb_dat;
  logic [10:0] rxb_adr;
  logic        rxb_we, irq;

  gpsreceiver2_capture #(.csr_addr(4'h0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .smp_stb(smp_stb), .smp_sign(smp_sign), .smp_mag(smp_mag), .pps(pps),
    .rxb_dat(rxb_dat), .rxb_adr(rxb_adr), .rxb_we(rxb_we), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        irq;
    logic [10:0] adr;
    logic [7:0]  dat;
  } wr_t;

  wr_t obs[$];
  int  irq_cnt;

  // Observed buffer writes and irq pulses, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rxb_we) obs.push_back('{irq: irq, adr: rxb_adr, dat: rxb_dat});
    if (irq) irq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_a  = {4'h0, 7'd0, a};
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] bank, input logic [2:0] a, output logic [31:0] d);
    csr_a = {bank, 7'd0, a};
    tick();
    d = csr_do;
  endtask

  task automatic send(input logic [1:0] s);
    smp_stb  = 1'b1;
    smp_sign = s[1];
    smp_mag  = s[0];
    tick();
    smp_stb  = 1'b0;
  endtask

  function automatic logic [1:0] pat_val(input int i);
    case (i % 4)
      0:       return 2'b01;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Start a capture, feed n samples, then compare writes and CSRs with the model.
  task automatic run_case(input int len, input bit cont, input int n, input bit pat,
                          input int maxgap, input bit do_abort);
    logic [1:0]  s[$];
    logic [31:0] d;
    int L, nb, nw, exp_irqs, m;
    bit busy, done, e_irq;
    s.delete();
    L  = (len == 0) ? 2048 : len;
    nb = n / 4;
    nw = cont ? nb : ((nb < L) ? nb : L);
    for (int i = 0; i < n; i++) s.push_back(pat ? pat_val(i) : 2'($urandom_range(0, 3)));

    csr_wr(3'd1, 32'(len));
    obs.delete();
    irq_cnt = 0;
    csr_wr(3'd0, {29'd0, cont, 2'b01});
    for (int i = 0; i < n; i++) begin
      send(s[i]);
      if (i % 4 == 3 && i / 4 < nw) begin
        chk("we_latency", 32'(rxb_we), 32'd1);
        chk("adr_latency", 32'(rxb_adr), 32'((i / 4) % L));
      end
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
    end
    repeat (4) tick();

    chk("num_writes", 32'(obs.size()), 32'(nw));
    exp_irqs = 0;
    m = (obs.size() < nw) ? obs.size() : nw;
    for (int i = 0; i < nw; i++) begin
      e_irq = cont ? ((i % L) == L - 1) : (i == L - 1);
      if (e_irq) exp_irqs++;
      if (i < m) begin
        chk("wr_adr", 32'(obs[i].adr), 32'(i % L));
        chk("wr_dat", 32'(obs[i].dat), 32'({s[4*i+3], s[4*i+2], s[4*i+1], s[4*i]}));
        chk("wr_irq", 32'(obs[i].irq), 32'(e_irq));
      end
    end
    chk("irq_count", 32'(irq_cnt), 32'(exp_irqs));

    busy = cont || (nb < L);
    done = !cont && (nb >= L);
    csr_rd(4'h0, 3'd1, d); chk("length", d, 32'(len));
    csr_rd(4'h0, 3'd2, d); chk("count", d, cont ? 32'(nb % L) : 32'(nw));
    csr_rd(4'h0, 3'd3, d); chk("wraps", d, cont ? 32'(nb / L) : 32'd0);
    csr_rd(4'h0, 3'd0, d);
    chk("ctrl", d, {26'd0, busy ? 2'd2 : 2'd0, 1'b0, cont, done, busy});
    if (do_abort && busy) begin
      csr_wr(3'd0, 32'h2);
      tick();
      csr_rd(4'h0, 3'd0, d); chk("ctrl_after_abort", d, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] d;
    sys_rst = 1'b1; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    smp_stb = 1'b0; smp_sign = 1'b0; smp_mag = 1'b0; pps = 1'b0;
    obs.delete(); irq_cnt = 0;
    repeat (3) tick();
    chk("rst_csr_do", csr_do, 32'd0);
    chk("rst_rxb_we", 32'(rxb_we), 32'd0);
    chk("rst_rxb_adr", 32'(rxb_adr), 32'd0);
    chk("rst_rxb_dat", 32'(rxb_dat), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    sys_rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      csr_rd(4'h0, 3'(r), d);
      chk("rst_reg", d, 32'd0);
    end

`ifndef GPSRECEIVER2_CAPTURE_TRIGGER_EN
    // Single-shot, fixed pattern, back-to-back strobes.
    run_case(4, 1'b0, 16, 1'b1, 0, 1'b0);
    csr_rd(4'h5, 3'd0, d); chk("unselected_bank", d, 32'd0);

    // Continuous, LENGTH=2, 24 strobes: three wraps, still busy.
    run_case(2, 1'b1, 24, 1'b0, 0, 1'b1);

    // Abort mid-byte, then a fresh start begins at address 0.
    run_case(8, 1'b0, 6, 1'b0, 1, 1'b1);
    run_case(4, 1'b0, 4, 1'b0, 0, 1'b0);

    // Start together with abort from IDLE: nothing happens.
    obs.delete();
    csr_wr(3'd0, 32'h3);
    for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 3)));
    repeat (2) tick();
    csr_rd(4'h0, 3'd0, d); chk("start_abort_ctrl", d & 32'h31, 32'd0);
    chk("start_abort_writes", 32'(obs.size()), 32'd0);

    // Start while capturing is ignored: COUNT keeps running.
    run_case(8, 1'b0, 8, 1'b0, 0, 1'b0);
    csr_wr(3'd0, 32'h1);
    tick();
    csr_rd(4'h0, 3'd2, d); chk("start_while_busy_count", d, 32'd2);
    csr_wr(3'd0, 32'h2);
    tick();

    // Random mix of lengths, modes, sample counts and gaps.
    for (int it = 0; it < 10; it++) begin
      int len;
      bit cont;
      len  = $urandom_range(1, 6);
      cont = 1'($urandom_range(0, 1));
      run_case(len, cont, $urandom_range(0, 4 * len * (cont ? 3 : 1) + 3), 1'b0, 2, 1'b1);
    end

    // LENGTH=0 means 2048 bytes: one full ring pass.
    run_case(0, 1'b1, 8192, 1'b0, 0, 1'b1);

    // Asynchronous reset mid-capture.
    csr_wr(3'd1, 32'd4);
    csr_wr(3'd0, 32'h1);
    for (int i = 0; i < 5; i++) send(pat_val(i));
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_rxb_dat", 32'(rxb_dat), 32'd0);
    chk("mid_rst_rxb_we", 32'(rxb_we), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();
    csr_rd(4'h0, 3'd0, d); chk("mid_rst_ctrl", d, 32'd0);
    csr_rd(4'h0, 3'd2, d); chk("mid_rst_count", d, 32'd0);
`else
    // pps-triggered capture: pre-edge and edge-cycle samples are dropped.
    begin
      logic [1:0] s[4];
      csr_wr(3'd1, 32'd1);
      obs.delete(); irq_cnt = 0;
      csr_wr(3'd0, 32'h1);
      csr_rd(4'h0, 3'd0, d); chk("armed_ctrl", d, 32'h11);
      for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)));
      csr_rd(4'h0, 3'd0, d); chk("still_armed", d, 32'h11);
      chk("armed_writes", 32'(obs.size()), 32'd0);
      pps = 1'b1;
      send(2'b11);
      for (int i = 0; i < 4; i++) begin
        s[i] = 2'($urandom_range(0, 3));
        send(s[i]);
      end
      pps = 1'b0;
      repeat (4) tick();
      chk("trig_writes", 32'(obs.size()), 32'd1);
      if (obs.size() > 0) begin
        chk("trig_adr", 32'(obs[0].adr), 32'd0);
        chk("trig_dat", 32'(obs[0].dat), 32'({s[3], s[2], s[1], s[0]}));
      end
      chk("trig_irq", 32'(irq_cnt), 32'd1);
      csr_rd(4'h0, 3'd0, d); chk("trig_ctrl", d, 32'h2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
